opamp_sar_readout: RTL and testbench
====================================

// Module: opamp_sar_readout
// PURPOSE
//  Digital SAR readout for the on-chip opamp: digitises the opamp output.
//  Drives an external R-2R DAC code on uo_out and a sample/hold strobe.
//  Reads back a single comparator bit on ui_in and returns an N-bit result with a start/done handshake.
//  Sits in the digital half of the opamp tile; the analog block is the source, this block is the reader.
// PARAMETERS
//  N_BITS        8  conversion width; also the DAC code width
//  SAMPLE_CYCLES 2  cycles sample is held high per conversion (>=1)
//  SETTLE_CYCLES 3  DAC/comparator settle cycles per bit (>=3, covers 2-flop sync)
// PORTS
//  clk       in  1       single clock; all state on rising edge
//  rst_n     in  1       synchronous active-low reset
//  ena       in  1       tile enable; low aborts to IDLE
//  start     in  1       conversion request, sampled only in IDLE
//  cmp_in    in  1       async comparator: 1 = V_opamp >= V_dac
//  dac_code  out N_BITS  trial code to R-2R DAC
//  sample    out 1       S/H strobe, high during SAMPLE
//  busy      out 1       high in every state except IDLE
//  done      out 1       1-cycle pulse, result valid
//  result    out N_BITS  last completed conversion; held until next done
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, dac_code=0, sample=0, busy=0, done=0, result=0, sync flops=0.
//  cmp_in passes through 2-flop synchroniser; only the synced value is used.
//  FSM: IDLE -> SAMPLE -> {SETTLE -> DECIDE} x N_BITS -> DONE -> IDLE.
//  IDLE: start=1 & ena=1 -> SAMPLE next cycle; code cleared to 0.
//  SAMPLE: sample=1 for SAMPLE_CYCLES cycles, dac_code=0.
//  SETTLE: dac_code = code | trial bit (MSB first); holds SETTLE_CYCLES cycles.
//  DECIDE: 1 cycle; synced cmp=1 keeps trial bit, 0 clears it; then next bit or DONE.
//  DONE: result<=code, done=1 for exactly this cycle; -> IDLE.
//  Latency: start sampled in cycle 0 -> done high in cycle 1+SAMPLE_CYCLES+N_BITS*(SETTLE_CYCLES+1).
//  start while busy: ignored, no queueing. start held high: new conversion begins the cycle after DONE.
//  ena=0 in any state: next edge -> IDLE, dac_code=0, sample=0, no done; result unchanged.
//  Reset mid-conversion: same as power-on reset, including result=0.
//  All arithmetic is unsigned; code never wraps (at most one bit set per step).
// CONFIGURATION
//  Macro OPAMP_SAR_AVG4_EN:
//   defined: one start runs 4 back-to-back conversions (SAMPLE..DECIDE x4).
//    Codes summed in an N_BITS+2 accumulator.
//    result = sum>>2 (truncate); a single done after the 4th.
//    Latency = 4*(SAMPLE_CYCLES+N_BITS*(SETTLE_CYCLES+1)) + 1.
//    ena=0 or reset clears accumulator and pass counter.
//   undefined: single conversion as above; no accumulator or pass counter synthesised.
// STRUCTURE
//  Package opamp_sar_pkg:
//   sar_state_t enum (IDLE, SAMPLE, SETTLE, DECIDE, DONE).
//   AVG_PASSES=4 and AVG_SHIFT=2 constants.
//  Sub-module opamp_sar_sync: 2-flop synchroniser for cmp_in, reset to 0.
//  Top level holds the FSM, settle/sample counter, bit index, code register and the optional accumulator.
// TESTING (N_BITS=8, SAMPLE_CYCLES=2, SETTLE_CYCLES=3)
//  Bench comparator model: cmp_in = (vin_code >= dac_code).
//  1. vin=0xA5, pulse start -> done exactly 35 cycles after start sample; result=0xA5; busy low next cycle.
//  2. vin=0x00 -> result=0x00; vin=0xFF -> result=0xFF; sample high exactly 2 cycles each.
//  3. start pulsed again at cycle 10 of a conversion -> ignored; single done; result unchanged by the extra pulse.
//  4. ena=0 at cycle 20 -> IDLE next edge, dac_code=0, no done; previous result retained.
//  5. rst_n=0 mid-conversion -> all outputs at reset values next edge; start afterwards converts normally.
//  6. OPAMP_SAR_AVG4_EN defined, vin sequence 10,11,12,13 -> one done after 137 cycles; result=11.

Source files
------------

// File: rtl/opamp_sar_pkg.sv
// Shared types and constants for the opamp SAR readout.
package opamp_sar_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        SETTLE = 3'd2,
        DECIDE = 3'd3,
        DONE   = 3'd4
    } sar_state_t;

    localparam int AVG_PASSES = 4;
    localparam int AVG_SHIFT  = 2;
endpackage

// File: rtl/opamp_sar_readout_if.sv
// Host-side start/done handshake and result bus of the SAR readout.
interface opamp_sar_readout_if #(parameter int N_BITS = 8);
    import opamp_sar_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic [N_BITS-1:0] result;

    modport master (output start, input busy, done, result);
    modport slave  (input start, output busy, done, result);
endinterface

// File: rtl/opamp_sar_sync.sv
// Two-flop synchroniser for the asynchronous comparator bit.
module opamp_sar_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/opamp_sar_readout.sv
// SAR readout of the opamp output through an external R-2R DAC and comparator.
// Define OPAMP_SAR_AVG4_EN to average four back-to-back conversions per start.
module opamp_sar_readout
    import opamp_sar_pkg::*;
#(
    parameter int N_BITS        = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cmp_in,
    output logic [N_BITS-1:0] dac_code,
    output logic              sample,
    opamp_sar_readout_if.slave host
);
    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_SAMPLE = SAMPLE;
    localparam logic [2:0] S_SETTLE = SETTLE;
    localparam logic [2:0] S_DECIDE = DECIDE;
    localparam logic [2:0] S_DONE   = DONE;

    localparam int IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [N_BITS-1:0] MSB = N_BITS'(1) << (N_BITS - 1);

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [N_BITS-1:0] code;
    logic [N_BITS-1:0] result;
    logic [N_BITS-1:0] mask;
    logic [N_BITS-1:0] decided;
    logic              cmp_s;

    opamp_sar_sync u_sync (.clk(clk), .rst_n(rst_n), .d(cmp_in), .q(cmp_s));

    // code already carries the trial bit, so a low comparator just drops it
    assign mask    = N_BITS'(1) << bit_idx;
    assign decided = cmp_s ? code : (code & ~mask);

`ifdef OPAMP_SAR_AVG4_EN
    localparam int PASS_W = $clog2(AVG_PASSES);
    logic [N_BITS+1:0] acc;
    logic [N_BITS+1:0] acc_next;
    logic [PASS_W-1:0] pass;
    assign acc_next = acc + {2'b00, decided};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            code    <= '0;
            result  <= '0;
`ifdef OPAMP_SAR_AVG4_EN
            acc     <= '0;
            pass    <= '0;
`endif
        end else if (!ena) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            code    <= '0;
`ifdef OPAMP_SAR_AVG4_EN
            acc     <= '0;
            pass    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (host.start) begin
                    state <= S_SAMPLE;
                    cnt   <= '0;
                    code  <= '0;
                end
                S_SAMPLE: if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
                    state   <= S_SETTLE;
                    cnt     <= '0;
                    bit_idx <= IDX_W'(N_BITS - 1);
                    code    <= MSB;
                end else cnt <= cnt + 1'b1;
                S_SETTLE: if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state <= S_DECIDE;
                    cnt   <= '0;
                end else cnt <= cnt + 1'b1;
                S_DECIDE: if (bit_idx != '0) begin
                    state   <= S_SETTLE;
                    bit_idx <= bit_idx - 1'b1;
                    code    <= decided | (mask >> 1);
                end else begin
`ifdef OPAMP_SAR_AVG4_EN
                    if (pass == PASS_W'(AVG_PASSES - 1)) begin
                        result <= acc_next[AVG_SHIFT +: N_BITS];
                        acc    <= '0;
                        pass   <= '0;
                        code   <= decided;
                        state  <= S_DONE;
                    end else begin
                        acc   <= acc_next;
                        pass  <= pass + 1'b1;
                        code  <= '0;
                        state <= S_SAMPLE;
                    end
`else
                    result <= decided;
                    code   <= decided;
                    state  <= S_DONE;
`endif
                end
                S_DONE: begin
                    state <= S_IDLE;
                    code  <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dac_code    = code;
    assign sample      = (state == S_SAMPLE);
    assign host.busy   = (state != S_IDLE);
    assign host.done   = (state == S_DONE);
    assign host.result = result;
endmodule

// File: tb/tb_opamp_sar_readout.sv
// Randomised bench for opamp_sar_readout against an ideal binary-search model.
module tb_opamp_sar_readout;
    localparam int N  = 8;
    localparam int SC = 2;
    localparam int ST = 3;
`ifdef OPAMP_SAR_AVG4_EN
    localparam int NPASS = 4;
`else
    localparam int NPASS = 1;
`endif
    localparam int PASS_LAT = SC + N * (ST + 1);
    localparam int EXP_LAT  = NPASS * PASS_LAT + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       cmp_in;
    logic       sample;
    logic [7:0] dac_code;
    logic [7:0] vin = 8'h00;
    logic [7:0] last_exp = 8'h00;
    int vectors = 0;
    int miscompares = 0;

    opamp_sar_readout_if #(.N_BITS(N)) host();

    opamp_sar_readout #(.N_BITS(N), .SAMPLE_CYCLES(SC), .SETTLE_CYCLES(ST)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cmp_in(cmp_in),
        .dac_code(dac_code), .sample(sample), .host(host)
    );

    always #5 clk = ~clk;
    assign cmp_in = (vin >= dac_code);

    function automatic logic [7:0] ref_sar(input logic [7:0] v);
        int code = 0;
        for (int b = N - 1; b >= 0; b--) begin
            int t = code | (1 << b);
            if (int'(v) >= t) code = t;
        end
        return 8'(code);
    endfunction

    function automatic logic [7:0] ref_result(input logic [3:0][7:0] vs);
        int s = 0;
        for (int p = 0; p < NPASS; p++) s += int'(ref_sar(vs[p]));
        return 8'(s / NPASS);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, feeds one input per sampling pass, returns cycles until done.
    task automatic run_conv(input logic [3:0][7:0] vs, input int extra_at,
                            output int lat, output int samp, output logic [7:0] res);
        int   pass = 0;
        logic prev = 1'b0;
        lat = -1; samp = 0; res = '0;
        vin = vs[0];
        host.start = 1'b1;
        for (int n = 1; n <= EXP_LAT + 20; n++) begin
            tick();
            host.start = (extra_at != 0 && n == extra_at);
            if (sample && !prev) begin
                if (pass < NPASS) vin = vs[pass];
                pass++;
            end
            prev = sample;
            if (sample) samp++;
            if (host.done) begin
                lat = n;
                res = host.result;
                break;
            end
        end
    endtask

    task automatic check_idle_zero(input string tag, input logic [7:0] exp_res);
        vectors++;
        if (dac_code !== 8'h00 || sample !== 1'b0 || host.busy !== 1'b0 ||
            host.done !== 1'b0 || host.result !== exp_res) begin
            miscompares++;
            $display("FAIL %s: dac=%h sample=%b busy=%b done=%b result=%h, want dac=00 sample=0 busy=0 done=0 result=%h",
                     tag, dac_code, sample, host.busy, host.done, host.result, exp_res);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; host.start = 1'b0;
        tick(); tick();
        check_idle_zero("reset", 8'h00);
        rst_n = 1'b1; ena = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int lat, samp; logic [7:0] res;
        logic [3:0][7:0] vs = {4{8'hA5}};
        run_conv(vs, 0, lat, samp, res);
        last_exp = ref_result(vs);
        vectors++;
        if (lat != EXP_LAT) begin miscompares++; $display("FAIL single_latency: got %0d want %0d", lat, EXP_LAT); end
        vectors++;
        if (res !== last_exp) begin miscompares++; $display("FAIL single_result: got %h want %h", res, last_exp); end
        tick();
        vectors++;
        if (host.busy !== 1'b0 || host.done !== 1'b0) begin
            miscompares++; $display("FAIL single_after_done: busy=%b done=%b want 0 0", host.busy, host.done);
        end
    endtask

    task automatic test_patterns();
        int lat, samp; logic [7:0] res;
        logic [3:0][7:0] vs;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) vs = '0;
            else if (i == 1) vs = '1;
            else vs = $urandom();
            run_conv(vs, 0, lat, samp, res);
            last_exp = ref_result(vs);
            vectors++;
            if (res !== last_exp || lat != EXP_LAT) begin
                miscompares++;
                $display("FAIL pattern_%0d: result=%h lat=%0d want %h lat=%0d", i, res, lat, last_exp, EXP_LAT);
            end
            vectors++;
            if (samp != NPASS * SC) begin
                miscompares++; $display("FAIL sample_width_%0d: got %0d want %0d", i, samp, NPASS * SC);
            end
            tick();
        end
    endtask

    task automatic test_busy_start();
        int lat, samp, extra_done = 0; logic [7:0] res;
        logic [3:0][7:0] vs = $urandom();
        run_conv(vs, 10, lat, samp, res);
        last_exp = ref_result(vs);
        vectors++;
        if (res !== last_exp || lat != EXP_LAT) begin
            miscompares++; $display("FAIL busy_start: result=%h lat=%0d want %h lat=%0d", res, lat, last_exp, EXP_LAT);
        end
        for (int n = 0; n < 40; n++) begin
            tick();
            if (host.done) extra_done++;
        end
        vectors++;
        if (extra_done != 0 || host.busy !== 1'b0) begin
            miscompares++; $display("FAIL busy_start_queued: extra dones=%0d busy=%b want 0 0", extra_done, host.busy);
        end
    endtask

    task automatic test_abort();
        int stray = 0;
        vin = 8'($urandom());
        host.start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            host.start = 1'b0;
        end
        ena = 1'b0;
        tick();
        check_idle_zero("abort", last_exp);
        for (int n = 0; n < EXP_LAT + 10; n++) begin
            if (n == 3) ena = 1'b1;
            tick();
            if (host.done) stray++;
        end
        vectors++;
        if (stray != 0 || host.result !== last_exp) begin
            miscompares++; $display("FAIL abort_no_done: dones=%0d result=%h want 0 %h", stray, host.result, last_exp);
        end
    endtask

    task automatic test_reset_mid();
        int lat, samp; logic [7:0] res;
        logic [3:0][7:0] vs = $urandom();
        vin = 8'($urandom());
        host.start = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            tick();
            host.start = 1'b0;
        end
        rst_n = 1'b0;
        tick();
        last_exp = 8'h00;
        check_idle_zero("reset_mid", last_exp);
        rst_n = 1'b1;
        tick();
        run_conv(vs, 0, lat, samp, res);
        last_exp = ref_result(vs);
        vectors++;
        if (res !== last_exp || lat != EXP_LAT) begin
            miscompares++; $display("FAIL reset_mid_reconvert: result=%h lat=%0d want %h lat=%0d", res, lat, last_exp, EXP_LAT);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n1 = -1, n2 = -1;
        logic [7:0] r1 = '0, r2 = '0;
        vin = 8'($urandom());
        last_exp = ref_sar(vin);
        host.start = 1'b1;
        for (int n = 1; n <= 2 * EXP_LAT + 20; n++) begin
            tick();
            if (host.done && n1 < 0) begin n1 = n; r1 = host.result; end
            else if (host.done) begin n2 = n; r2 = host.result; host.start = 1'b0; break; end
        end
        host.start = 1'b0;
        vectors++;
        if (n1 != EXP_LAT || n2 - n1 != EXP_LAT + 1) begin
            miscompares++; $display("FAIL held_start_timing: first=%0d gap=%0d want %0d %0d", n1, n2 - n1, EXP_LAT, EXP_LAT + 1);
        end
        vectors++;
        if (r1 !== last_exp || r2 !== last_exp) begin
            miscompares++; $display("FAIL held_start_result: %h %h want %h", r1, r2, last_exp);
        end
        tick(); tick();
        vectors++;
        if (host.busy !== 1'b0) begin miscompares++; $display("FAIL held_start_release: busy=%b want 0", host.busy); end
    endtask

`ifdef OPAMP_SAR_AVG4_EN
    task automatic test_avg();
        int lat, samp; logic [7:0] res;
        logic [3:0][7:0] vs = {8'd13, 8'd12, 8'd11, 8'd10};
        run_conv(vs, 0, lat, samp, res);
        vectors++;
        if (lat != 137 || res !== 8'd11) begin
            miscompares++; $display("FAIL avg4: lat=%0d result=%0d want 137 11", lat, res);
        end
        tick();
    endtask
`endif

    initial begin
        host.start = 1'b0;
        test_reset();
        test_single();
        test_patterns();
        test_busy_start();
        test_abort();
        test_reset_mid();
        test_back_to_back();
`ifdef OPAMP_SAR_AVG4_EN
        test_avg();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
